prco_encoder: RTL and testbench

Instruction encoder and program loader for the PRCO core: the write-side counterpart of the instruction decoder. It accepts instructions in field form (opcode, destination, source, immediates) through a valid/ready handshake. It packs each one into the 16-bit PRCO instruction word, buffers it in a small FIFO, and writes it to sequential instruction-memory addresses through a write port with backpressure.

---
 rtl/prco_encoder_pkg.sv | 63 ++++++
 rtl/prco_sync_fifo.sv | 47 ++++
 rtl/prco_encoder.sv | 114 +++++++++++
 tb/tb_prco_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prco_encoder_pkg.sv
// Shared PRCO ISA opcodes, instruction field layout and the encoder's pack function.
// The `PRCO_OP_*` / `PRCO_F_*` defines mirror inc/prco_isa.v so decoder and encoder agree on one layout.
`ifndef PRCO_ISA_DEFS
`define PRCO_ISA_DEFS
`define PRCO_OP_NOP      5'h00
`define PRCO_OP_MOV      5'h01
`define PRCO_OP_MOVI     5'h02
`define PRCO_OP_ADD      5'h03
`define PRCO_OP_LW       5'h04
`define PRCO_F_OP_HI     15
`define PRCO_F_OP_LO     11
`define PRCO_F_SELD_HI   10
`define PRCO_F_SELD_LO   8
`define PRCO_F_SELA_HI   7
`define PRCO_F_SELA_LO   5
`define PRCO_F_IMM8_HI   7
`define PRCO_F_IMM8_LO   0
`define PRCO_F_SIMM5_HI  4
`define PRCO_F_SIMM5_LO  0
`endif

package prco_encoder_pkg;

  localparam logic [4:0] OP_NOP  = `PRCO_OP_NOP;
  localparam logic [4:0] OP_MOV  = `PRCO_OP_MOV;
  localparam logic [4:0] OP_MOVI = `PRCO_OP_MOVI;
  localparam logic [4:0] OP_ADD  = `PRCO_OP_ADD;
  localparam logic [4:0] OP_LW   = `PRCO_OP_LW;

  typedef logic [15:0] insn_t;

  function automatic logic prco_op_valid(input logic [4:0] op);
    return (op == OP_NOP) || (op == OP_MOV) || (op == OP_MOVI) ||
           (op == OP_ADD) || (op == OP_LW);
  endfunction

  // Unknown opcodes fall into the register-register form; filtering them is the caller's job.
  function automatic insn_t prco_encode(input logic [4:0] op, input logic [2:0] seld,
                                        input logic [2:0] sela, input logic [7:0] imm8,
                                        input logic [4:0] simm5);
    insn_t w;
    w = '0;
    w[`PRCO_F_OP_HI:`PRCO_F_OP_LO] = op;
    case (op)
      OP_NOP: ;
      OP_MOVI: begin
        w[`PRCO_F_SELD_HI:`PRCO_F_SELD_LO] = seld;
        w[`PRCO_F_IMM8_HI:`PRCO_F_IMM8_LO] = imm8;
      end
      OP_LW: begin
        w[`PRCO_F_SELD_HI:`PRCO_F_SELD_LO]   = seld;
        w[`PRCO_F_SELA_HI:`PRCO_F_SELA_LO]   = sela;
        w[`PRCO_F_SIMM5_HI:`PRCO_F_SIMM5_LO] = simm5;
      end
      default: begin
        w[`PRCO_F_SELD_HI:`PRCO_F_SELD_LO] = seld;
        w[`PRCO_F_SELA_HI:`PRCO_F_SELA_LO] = sela;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/prco_sync_fifo.sv
// Synchronous FIFO with flush; head word is visible combinationally on rdata.
// Latency: push at edge E is readable after E. Caller must not push when full nor pop when empty.
module prco_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/prco_encoder.sv
// PRCO instruction encoder/loader: packs fields to 16-bit words, queues them, writes sequential addresses.
// Latency: accept at E0 -> popped at E0+1 -> write done at E0+2 earliest. Holds addr/data until i_mem_ready.
// Optional opcode filtering under PRCO_ENC_CHECK_EN.
module prco_encoder
  import prco_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     q_ready,
  input  logic [4:0]               i_op,
  input  logic [2:0]               i_seld,
  input  logic [2:0]               i_sela,
  input  logic [7:0]               i_imm8,
  input  logic [4:0]               i_simm5,
  input  logic                     i_load,
  input  logic [AW-1:0]            i_load_addr,
  input  logic                     i_mem_ready,
  output logic                     q_mem_we,
  output logic [AW-1:0]            q_mem_addr,
  output logic [15:0]              q_mem_data,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_err,
  output logic                     q_wrap
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [0:0]    state;
  logic          accept;
  logic          op_ok;
  logic          push;
  logic          pop;
  logic          wr_done;
  logic          fifo_empty;
  insn_t         fifo_rdata;
  insn_t         enc_word;
  logic [CW-1:0] cnt_next;

`ifdef PRCO_ENC_CHECK_EN
  assign op_ok = prco_op_valid(i_op);
`else
  assign op_ok = 1'b1;
`endif

  assign accept   = i_valid && q_ready && !i_load;
  assign push     = accept && op_ok;
  assign enc_word = prco_encode(i_op, i_seld, i_sela, i_imm8, i_simm5);
  assign wr_done  = (state == ST_WRITE) && i_mem_ready;
  assign pop      = !i_load && !fifo_empty && ((state == ST_IDLE) || wr_done);
  assign q_mem_we = (state == ST_WRITE);

  prco_sync_fifo #(.W(16), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .flush   (i_load),
    .push    (push),
    .wdata   (enc_word),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .count   (q_count),
    .empty   (fifo_empty)
  );

  // Ready is registered, so it is computed from the occupancy the FIFO will have after this edge.
  always_comb begin
    cnt_next = q_count;
    if (i_load) begin
      cnt_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_next = q_count + CW'(1);
        2'b01:   cnt_next = q_count - CW'(1);
        default: cnt_next = q_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      q_ready    <= 1'b1;
      q_mem_addr <= '0;
      q_mem_data <= '0;
      q_err      <= 1'b0;
      q_wrap     <= 1'b0;
    end else begin
      q_ready <= (cnt_next < CW'(DEPTH));
      if (accept && !op_ok) q_err <= 1'b1;
      if (i_load) begin
        state      <= ST_IDLE;
        q_mem_addr <= i_load_addr;
        q_wrap     <= 1'b0;
      end else begin
        if (wr_done) begin
          q_mem_addr <= q_mem_addr + AW'(1);
          if (&q_mem_addr) q_wrap <= 1'b1;
        end
        if (pop) begin
          q_mem_data <= fifo_rdata;
          state      <= ST_WRITE;
        end else if (wr_done) begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prco_encoder.sv
// Scoreboard bench for prco_encoder: expected {addr,word} queued at accept, checked at each memory write.
module tb_prco_encoder;
  import prco_encoder_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        q_ready;
  logic [4:0]  i_op = '0;
  logic [2:0]  i_seld = '0;
  logic [2:0]  i_sela = '0;
  logic [7:0]  i_imm8 = '0;
  logic [4:0]  i_simm5 = '0;
  logic        i_load = 1'b0;
  logic [7:0]  i_load_addr = '0;
  logic        i_mem_ready = 1'b0;
  logic        q_mem_we;
  logic [7:0]  q_mem_addr;
  logic [15:0] q_mem_data;
  logic [2:0]  q_count;
  logic        q_err;
  logic        q_wrap;

  int total = 0;
  int bad = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  exp_addr = '0;
  logic        hold_vld = 1'b0;
  logic [7:0]  hold_addr;
  logic [15:0] hold_data;

  prco_encoder #(.DEPTH(4), .AW(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .q_ready(q_ready),
    .i_op(i_op), .i_seld(i_seld), .i_sela(i_sela), .i_imm8(i_imm8), .i_simm5(i_simm5),
    .i_load(i_load), .i_load_addr(i_load_addr), .i_mem_ready(i_mem_ready),
    .q_mem_we(q_mem_we), .q_mem_addr(q_mem_addr), .q_mem_data(q_mem_data),
    .q_count(q_count), .q_err(q_err), .q_wrap(q_wrap)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoding written straight from the field layout table.
  function automatic logic [15:0] ref_word(input logic [4:0] op, input logic [2:0] d,
                                           input logic [2:0] a, input logic [7:0] imm,
                                           input logic [4:0] s);
    case (op)
      5'h00:   return {op, 11'b0};
      5'h02:   return {op, d, imm};
      5'h04:   return {op, d, a, s};
      default: return {op, d, a, 5'b0};
    endcase
  endfunction

  task automatic drive(input logic [4:0] op, input logic [2:0] d, input logic [2:0] a,
                       input logic [7:0] imm, input logic [4:0] s, input logic expect_wr);
    i_valid = 1'b1; i_op = op; i_seld = d; i_sela = a; i_imm8 = imm; i_simm5 = s;
    if (expect_wr) begin
      exp_q.push_back({exp_addr, ref_word(op, d, a, imm, s)});
      exp_addr = exp_addr + 8'd1;
    end
  endtask

  task automatic send(input logic [4:0] op, input logic [2:0] d, input logic [2:0] a,
                      input logic [7:0] imm, input logic [4:0] s, input logic expect_wr);
    int n = 0;
    while (!q_ready && n < 50) begin
      @(posedge i_clk); #1; n++;
    end
    if (!q_ready) chk("ready_timeout", 0, 1);
    drive(op, d, a, imm, s, expect_wr);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !q_mem_we && q_count == 3'd0) begin
        done = 1'b1;
        break;
      end
      @(posedge i_clk); #1;
    end
    chk("drain_done", {31'b0, done}, 1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
    end
  endtask

  // Write monitor: a write completes on the edge following a negedge with we && ready.
  always @(negedge i_clk) begin
    if (!i_rst_n || i_load) begin
      hold_vld = 1'b0;
    end else if (q_mem_we) begin
      if (hold_vld) begin
        chk("hold_addr", {24'b0, q_mem_addr}, {24'b0, hold_addr});
        chk("hold_data", {16'b0, q_mem_data}, {16'b0, hold_data});
      end
      if (i_mem_ready) begin
        hold_vld = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'b0, q_mem_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {24'b0, q_mem_addr}, {24'b0, e[23:16]});
          chk("wr_data", {16'b0, q_mem_data}, {16'b0, e[15:0]});
        end
      end else begin
        hold_vld  = 1'b1;
        hold_addr = q_mem_addr;
        hold_data = q_mem_data;
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  initial begin
    // Reset
    step(3);
    i_rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'b0, q_ready}, 1);
    chk("rst_we",    {31'b0, q_mem_we}, 0);
    chk("rst_addr",  {24'b0, q_mem_addr}, 0);
    chk("rst_data",  {16'b0, q_mem_data}, 0);
    chk("rst_count", {29'b0, q_count}, 0);
    chk("rst_err",   {31'b0, q_err}, 0);
    chk("rst_wrap",  {31'b0, q_wrap}, 0);
    step(1);

    // MOVI r3,0x5A then LW r2,-3(r1); check write latency
    i_mem_ready = 1'b1;
    drive(OP_MOVI, 3'd3, 3'd0, 8'h5A, 5'd0, 1'b1);
    @(posedge i_clk); #1;
    chk("lat_we_e0", {31'b0, q_mem_we}, 0);
    drive(OP_LW, 3'd2, 3'd1, 8'd0, 5'b11101, 1'b1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("lat_we_e1", {31'b0, q_mem_we}, 1);
    chk("lat_data",  {16'b0, q_mem_data}, {16'b0, OP_MOVI, 3'd3, 8'h5A});
    wait_drain();
    chk("addr_after2", {24'b0, q_mem_addr}, 2);

    // Backpressure: 5 words with memory stalled
    i_mem_ready = 1'b0;
    send(OP_ADD,  3'd1, 3'd2, 8'd0,  5'd0, 1'b1);
    send(OP_MOV,  3'd4, 3'd5, 8'd0,  5'd0, 1'b1);
    send(OP_NOP,  3'd7, 3'd7, 8'hFF, 5'h1F, 1'b1);
    send(OP_MOVI, 3'd6, 3'd0, 8'hC3, 5'd0, 1'b1);
    send(OP_LW,   3'd0, 3'd7, 8'd0,  5'b01111, 1'b1);
    chk("full_ready", {31'b0, q_ready}, 0);
    chk("full_count", {29'b0, q_count}, 4);
    step(3);
    chk("stall_data", {16'b0, q_mem_data}, {16'b0, ref_word(OP_ADD, 3'd1, 3'd2, 8'd0, 5'd0)});
    chk("stall_addr", {24'b0, q_mem_addr}, 2);
    i_mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_we", {31'b0, q_mem_we}, 1);
      @(posedge i_clk); #1;
    end
    chk("b2b_end_we", {31'b0, q_mem_we}, 0);
    chk("b2b_empty", exp_q.size(), 0);
    chk("b2b_ready", {31'b0, q_ready}, 1);

    // Load at FE, three words wrap through FF to 00
    i_load = 1'b1; i_load_addr = 8'hFE;
    i_valid = 1'b1; i_op = OP_ADD; i_seld = 3'd5; i_sela = 3'd5;
    @(posedge i_clk); #1;
    i_load = 1'b0; i_valid = 1'b0;
    exp_addr = 8'hFE;
    chk("load_addr", {24'b0, q_mem_addr}, 32'hFE);
    chk("load_count", {29'b0, q_count}, 0);
    send(OP_MOVI, 3'd1, 3'd0, 8'h11, 5'd0, 1'b1);
    send(OP_MOVI, 3'd2, 3'd0, 8'h22, 5'd0, 1'b1);
    send(OP_MOVI, 3'd3, 3'd0, 8'h33, 5'd0, 1'b1);
    wait_drain();
    chk("wrap_set", {31'b0, q_wrap}, 1);
    chk("wrap_addr", {24'b0, q_mem_addr}, 1);

    // Load mid-WRITE with two words queued
    i_mem_ready = 1'b0;
    send(OP_ADD, 3'd1, 3'd1, 8'd0, 5'd0, 1'b1);
    send(OP_ADD, 3'd2, 3'd2, 8'd0, 5'd0, 1'b1);
    send(OP_ADD, 3'd3, 3'd3, 8'd0, 5'd0, 1'b1);
    chk("pre_load_cnt", {29'b0, q_count}, 2);
    chk("pre_load_we", {31'b0, q_mem_we}, 1);
    i_load = 1'b1; i_load_addr = 8'h40;
    exp_q.delete();
    exp_addr = 8'h40;
    @(posedge i_clk); #1;
    i_load = 1'b0;
    chk("ld_we", {31'b0, q_mem_we}, 0);
    chk("ld_count", {29'b0, q_count}, 0);
    chk("ld_addr", {24'b0, q_mem_addr}, 32'h40);
    chk("ld_wrap", {31'b0, q_wrap}, 0);
    chk("ld_ready", {31'b0, q_ready}, 1);
    i_mem_ready = 1'b1;
    step(6);
    chk("ld_no_write", {31'b0, q_mem_we}, 0);
    chk("ld_addr_held", {24'b0, q_mem_addr}, 32'h40);

    // Unknown opcode
`ifdef PRCO_ENC_CHECK_EN
    send(5'h1F, 3'd6, 3'd2, 8'd0, 5'd0, 1'b0);
    step(4);
    chk("bad_op_we", {31'b0, q_mem_we}, 0);
    chk("bad_op_err", {31'b0, q_err}, 1);
    chk("bad_op_count", {29'b0, q_count}, 0);
    i_load = 1'b1; i_load_addr = 8'h00;
    @(posedge i_clk); #1;
    i_load = 1'b0;
    chk("err_sticky", {31'b0, q_err}, 1);
`else
    send(5'h1F, 3'd6, 3'd2, 8'd0, 5'd0, 1'b1);
    wait_drain();
    chk("bad_op_err", {31'b0, q_err}, 0);
    chk("bad_op_addr", {24'b0, q_mem_addr}, 32'h41);
`endif

    // Reset mid-operation
    i_mem_ready = 1'b0;
    send(OP_MOV, 3'd1, 3'd2, 8'd0, 5'd0, 1'b1);
    send(OP_MOV, 3'd3, 3'd4, 8'd0, 5'd0, 1'b1);
    i_rst_n = 1'b0;
    exp_q.delete();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chk("rst2_we", {31'b0, q_mem_we}, 0);
    chk("rst2_count", {29'b0, q_count}, 0);
    chk("rst2_addr", {24'b0, q_mem_addr}, 0);
    chk("rst2_err", {31'b0, q_err}, 0);
    step(2);
    chk("end_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
